// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Arbitrates the in-order pipeline WB stage and the long-latency MDU onto the
//   single register-file write port. WB has priority. An MDU result that has
//   been refused for STARVE_LIMIT consecutive cycles wins the next arbitration.
//   A per-register scoreboard tracks MDU destinations still in flight and
//   flags read-after-write hazards on the decode source operands.
//
// Optional feature macro: REGFILE_WB_ARB_SB_CHECK_EN
//   When defined, sb_err_o is a sticky flag. It is set by an issue to a
//   register that is already pending. It is also set by an MDU transfer to a
//   register that is neither pending nor being set in the same cycle.
//   When undefined, sb_err_o is tied to 0 and no check logic is built.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   wb_valid_i/ready_o      WB write request / accepted this cycle
//   wb_addr_i, wb_data_i    WB destination register and data
//   mdu_valid_i/ready_o     MDU write request / accepted this cycle
//   mdu_addr_i, mdu_data_i  MDU destination register and result
//   issue_i, issue_addr_i   MDU op issued; its destination becomes pending
//   rs1_addr_i, rs2_addr_i  decode source operands
//   hazard_o                a source operand is pending (combinational)
//   rf_w_ena_o/addr_o/data_o registered register-file write port
//   sb_err_o                sticky scoreboard protocol error
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    wb_valid_i,
  output logic                    wb_ready_o,
  input  logic [$clog2(NREG)-1:0] wb_addr_i,
  input  logic [XLEN-1:0]         wb_data_i,

  input  logic                    mdu_valid_i,
  output logic                    mdu_ready_o,
  input  logic [$clog2(NREG)-1:0] mdu_addr_i,
  input  logic [XLEN-1:0]         mdu_data_i,

  input  logic                    issue_i,
  input  logic [$clog2(NREG)-1:0] issue_addr_i,

  input  logic [$clog2(NREG)-1:0] rs1_addr_i,
  input  logic [$clog2(NREG)-1:0] rs2_addr_i,
  output logic                    hazard_o,

  output logic                    rf_w_ena_o,
  output logic [$clog2(NREG)-1:0] rf_w_addr_o,
  output logic [XLEN-1:0]         rf_w_data_o,

  output logic                    sb_err_o
);

  localparam int AW = $clog2(NREG);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [3:0]      starve_cnt_reg;
  logic [3:0]      starve_cnt_next;
  logic            force_mdu;
  logic            wb_xfer;
  logic            mdu_xfer;
  logic            grant_any;
  logic [AW-1:0]   grant_addr;
  logic [XLEN-1:0] grant_data;

  assign force_mdu   = (starve_cnt_reg == STARVE_MAX);
  assign wb_ready_o  = wb_valid_i && !force_mdu;
  assign mdu_ready_o = mdu_valid_i && (!wb_valid_i || force_mdu);

  // A ready is only ever raised together with its valid, so ready alone
  // already means a transfer happens this cycle.
  assign wb_xfer  = wb_ready_o;
  assign mdu_xfer = mdu_ready_o;

  assign grant_any  = wb_xfer || mdu_xfer;
  assign grant_addr = mdu_xfer ? mdu_addr_i : wb_addr_i;
  assign grant_data = mdu_xfer ? mdu_data_i : wb_data_i;

  // Counts consecutive cycles the MDU was refused; saturates so force_mdu
  // stays asserted until the MDU actually transfers.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!mdu_valid_i || mdu_xfer) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  logic            rf_w_ena_reg;
  logic            rf_w_ena_next;
  logic [AW-1:0]   rf_w_addr_reg;
  logic [XLEN-1:0] rf_w_data_reg;

  // x0 transfers complete their handshake but never write.
  assign rf_w_ena_next = grant_any && (grant_addr != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_reg <= '0;
      rf_w_ena_reg   <= 1'b0;
      rf_w_addr_reg  <= '0;
      rf_w_data_reg  <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rf_w_ena_reg   <= rf_w_ena_next;
      if (rf_w_ena_next) begin
        rf_w_addr_reg <= grant_addr;
        rf_w_data_reg <= grant_data;
      end
    end
  end

  assign rf_w_ena_o  = rf_w_ena_reg;
  assign rf_w_addr_o = rf_w_addr_reg;
  assign rf_w_data_o = rf_w_data_reg;

  // ---------------------------------------------------------------------------
  // Scoreboard of in-flight MDU destinations
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] sb_reg;
  logic [NREG-1:0] sb_next;

  // x0 can never be pending.
  assign sb_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_sb
      // Set is applied after clear so a same-cycle issue keeps the bit set.
      assign sb_next[gi] = (issue_i && (issue_addr_i == AW'(gi))) ||
                           (sb_reg[gi] && !(mdu_xfer && (mdu_addr_i == AW'(gi))));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  // Looked up in the pre-update scoreboard; sb_reg[0] is always 0.
  assign hazard_o = sb_reg[rs1_addr_i] || sb_reg[rs2_addr_i];

  // ---------------------------------------------------------------------------
  // Scoreboard protocol check
  // ---------------------------------------------------------------------------
`ifdef REGFILE_WB_ARB_SB_CHECK_EN
  logic issue_real;
  logic issue_dup;
  logic clear_unset;
  logic sb_err_reg;

  assign issue_real  = issue_i && (issue_addr_i != '0);
  assign issue_dup   = issue_real && sb_reg[issue_addr_i];
  assign clear_unset = mdu_xfer && !sb_reg[mdu_addr_i] &&
                       !(issue_real && (issue_addr_i == mdu_addr_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_err_reg <= 1'b0;
    end else if (issue_dup || clear_unset) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err_o = sb_err_reg;
`else
  assign sb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Scoreboard bench for regfile_wb_arbiter. The stimulus process drives one
// request set per cycle. It checks the combinational outputs against a
// behavioural model and queues every expected register-file write. A separate
// monitor pops the queue whenever rf_w_ena_o is seen. On idle cycles the
// monitor checks that addr/data hold and that no expected write went missing.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, mdu_valid = 1'b0, issue = 1'b0;
  logic [4:0]  wb_addr = '0, mdu_addr = '0, issue_addr = '0, rs1 = '0, rs2 = '0;
  logic [31:0] wb_data = '0, mdu_data = '0;
  logic        wb_ready, mdu_ready, hazard, rf_w_ena, sb_err;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready), .mdu_addr_i(mdu_addr), .mdu_data_i(mdu_data),
    .issue_i(issue), .issue_addr_i(issue_addr),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .hazard_o(hazard),
    .rf_w_ena_o(rf_w_ena), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data),
    .sb_err_o(sb_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference model state
  wr_t         exp_q[$];
  bit          pend[NREG];
  int          waited;
  bit          err_m;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  wr_t         mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one line per register-file write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_w_ena) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h, required no write", rf_w_addr, rf_w_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("w_addr", {27'd0, rf_w_addr}, {27'd0, mon_e.a});
          check("w_data", rf_w_data, mon_e.d);
          $display("WR addr=%0d data=%h", rf_w_addr, rf_w_data);
          last_a = mon_e.a;
          last_d = mon_e.d;
        end
      end else begin
        check("missing_write", exp_q.size(), 0);
        check("hold_addr", {27'd0, rf_w_addr}, {27'd0, last_a});
        check("hold_data", rf_w_data, last_d);
      end
    end
  end

  // One cycle of stimulus, with expectations computed from the arbitration,
  // scoreboard and starvation rules.
  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic iss, input logic [4:0] ia,
                      input logic [4:0] r1, input logic [4:0] r2,
                      output bit wacc, output bit macc);
    bit fm, ew, em, eh;
    @(negedge clk);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    issue = iss; issue_addr = ia; rs1 = r1; rs2 = r2;
    #1;
    fm = (waited == LIMIT);
    ew = wv && !fm;
    em = mv && (!wv || fm);
    eh = pend[r1] || pend[r2];
    check("wb_ready", {31'd0, wb_ready}, {31'd0, ew});
    check("mdu_ready", {31'd0, mdu_ready}, {31'd0, em});
    check("hazard", {31'd0, hazard}, {31'd0, eh});
    check("sb_err", {31'd0, sb_err}, {31'd0, err_m});
    if (ew && wa != 0) exp_q.push_back(wr_t'{a: wa, d: wd});
    if (em && ma != 0) exp_q.push_back(wr_t'{a: ma, d: md});
`ifdef REGFILE_WB_ARB_SB_CHECK_EN
    if (iss && ia != 0 && pend[ia]) err_m = 1'b1;
    if (em && !pend[ma] && !(iss && ia != 0 && ia == ma)) err_m = 1'b1;
`endif
    if (em) pend[ma] = 1'b0;
    if (iss && ia != 0) pend[ia] = 1'b1;
    if (!mv || em) waited = 0;
    else if (waited < LIMIT) waited++;
    wacc = ew;
    macc = em;
  endtask

  // Asserts reset mid-cycle (a grant may be in flight), checks the outputs
  // clear at once, and releases after the next falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    wb_valid = 0; mdu_valid = 0; issue = 0;
    #1;
    check("rst_ena", {31'd0, rf_w_ena}, 0);
    check("rst_addr", {27'd0, rf_w_addr}, 0);
    check("rst_data", rf_w_data, 0);
    check("rst_err", {31'd0, sb_err}, 0);
    exp_q.delete();
    for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
    waited = 0;
    err_m = 1'b0;
    last_a = '0;
    last_d = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit wacc, macc;
    bit wbp, mdp;
    logic [4:0]  rwa, rma;
    logic [31:0] rwd, rmd;

    do_reset();

    // WB only, then an x0 write that must not reach the register file
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    step(1, 5'd0, 32'h00001234, 0, 0, 0, 0, 0, 0, 0, wacc, macc);

    // MDU write to a register never issued
    step(0, 0, 0, 1, 5'd3, 32'hA5A5A5A5, 0, 0, 0, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    do_reset();

    // Contention: WB wins four cycles, then the starved MDU is forced through
    for (int i = 0; i < 5; i++)
      step(1, 5'(i + 1), 32'h100 + i, 1, 5'd7, 32'h55, 0, 0, 0, 0, wacc, macc);
    step(1, 5'd5, 32'h104, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wacc, macc);

    // Scoreboard on x9: set, hazard, clear
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, wacc, macc);
    step(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd9, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, wacc, macc);
    // Same-cycle issue and clear of x9: the set wins
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, wacc, macc);
    step(0, 0, 0, 1, 5'd9, 32'h98, 1, 5'd9, 5'd9, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, wacc, macc);

    // Reset while x9 is pending and a WB grant is in flight
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, wacc, macc);
    step(1, 5'd4, 32'hCAFE0004, 0, 0, 0, 0, 0, 5'd9, 0, wacc, macc);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9, wacc, macc);

    // Randomized traffic; requesters hold their request until accepted
    wbp = 0; mdp = 0;
    rwa = '0; rma = '0; rwd = '0; rmd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!wbp && $urandom_range(0, 2) != 0) begin
        wbp = 1; rwa = 5'($urandom_range(0, 31)); rwd = $urandom;
      end
      if (!mdp && $urandom_range(0, 2) == 0) begin
        mdp = 1; rma = 5'($urandom_range(0, 31)); rmd = $urandom;
      end
      step(wbp, rwa, rwd, mdp, rma, rmd,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), wacc, macc);
      if (wacc) wbp = 0;
      if (macc) mdp = 0;
      if (i == 200) begin
        do_reset();
        wbp = 0;
        mdp = 0;
      end
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wacc, macc);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates two writeback sources onto the single register-file write port (w_ena/w_addr/w_data): the in-order pipeline WB stage and the long-latency multiply/divide unit (MDU).
- Holds a per-register scoreboard of MDU destinations still in flight and flags read-after-write hazards for the decode/EX source operands.
- Sits between WB/MDU and the 1W/2R register file.

Parameters:
XLEN, 32, data width of write data.
NREG, 32, number of architectural registers; the address width is log2(NREG) = 5.
STARVE_LIMIT, 4, consecutive MDU-stalled cycles before the MDU forcibly wins arbitration; legal range 1..15.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
wb_valid_i  in  1  pipeline WB write request.
wb_ready_o  out  1  WB request accepted this cycle.
wb_addr_i  in  5  WB destination register.
wb_data_i  in  XLEN  WB write data.
mdu_valid_i  in  1  MDU result write request.
mdu_ready_o  out  1  MDU request accepted this cycle.
mdu_addr_i  in  5  MDU destination register.
mdu_data_i  in  XLEN  MDU result.
issue_i  in  1  MDU op issued; marks its destination pending.
issue_addr_i  in  5  destination of the issued MDU op.
rs1_addr_i  in  5  source 1 of the instruction in decode.
rs2_addr_i  in  5  source 2 of the instruction in decode.
hazard_o  out  1  a source register is pending in the scoreboard.
rf_w_ena_o  out  1  register-file write enable (registered).
rf_w_addr_o  out  5  register-file write address (registered).
rf_w_data_o  out  XLEN  register-file write data (registered).
sb_err_o  out  1  sticky scoreboard protocol error; see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert by the system) clears the following to 0:
  - rf_w_ena_o, rf_w_addr_o, rf_w_data_o, sb_err_o
  - all scoreboard bits
  - starve_cnt
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - ready is combinational from the valids and starve_cnt.
  - A requester holds addr and data stable while valid && !ready.
- Arbitration, with at most one grant per cycle:
  - Default: WB has priority. wb_ready_o = wb_valid_i && !force_mdu. mdu_ready_o = mdu_valid_i && (!wb_valid_i || force_mdu).
  - force_mdu = (starve_cnt == STARVE_LIMIT).
- starve_cnt, 4-bit, evaluated each clock:
  - Clears to 0 on an MDU transfer or when mdu_valid_i = 0.
  - Otherwise increments when mdu_valid_i && !mdu_ready_o, saturating at STARVE_LIMIT.
- Write port latency:
  - The granted transfer in cycle N appears on rf_w_* in cycle N+1 for exactly one cycle.
  - rf_w_ena_o = 1 only if the granted address != 0. An x0 transfer still completes its handshake but produces rf_w_ena_o = 0.
  - rf_w_addr_o and rf_w_data_o hold their last value when rf_w_ena_o = 0.
- Scoreboard (NREG bits, bit 0 hard-wired 0):
  - issue_i sets bit[issue_addr_i]; ignored for address 0.
  - An MDU transfer clears bit[mdu_addr_i].
  - If the set and the clear target the same register in the same cycle, the set wins and the bit stays 1.
  - WB transfers never touch the scoreboard.
- hazard_o is combinational: bit[rs1_addr_i] || bit[rs2_addr_i], evaluated against the current (pre-update) scoreboard. An address of 0 never raises a hazard.
- Reset mid-operation: pending bits and any granted-but-not-yet-written result are discarded. rf_w_ena_o is 0 from reset assertion onward.

Optional Feature:
Macro: REGFILE_WB_ARB_SB_CHECK_EN.
- Defined:
  - sb_err_o is set, and stays set until reset, when issue_i targets a register whose bit is already 1.
  - sb_err_o is also set when an MDU transfer targets a register whose bit is 0 and which is not being set in the same cycle.
- Undefined: sb_err_o is tied to 0 and no check logic is built.

Test Plan:
- WB only: wb_valid_i=1, addr=5, data=0xDEADBEEF -> wb_ready_o=1 same cycle; next cycle rf_w_ena_o=1, addr=5, data=0xDEADBEEF.
- x0 write: WB addr=0, data=0x1234 -> handshake completes; rf_w_ena_o stays 0.
- Contention and starvation, STARVE_LIMIT=4: wb_valid_i held 1 (addr 1..) and mdu_valid_i=1 (addr=7, data=0x55) from cycle 0.
  - Cycles 0-3 grant WB.
  - Cycle 4 grants MDU with wb_ready_o=0.
  - Cycle 5 shows rf_w_addr_o=7, data=0x55.
  - starve_cnt returns to 0.
- Scoreboard: issue_i with addr=9, then rs1_addr_i=9 -> hazard_o=1 from the next cycle until the cycle after the MDU transfer to 9.
  - The same-cycle issue-and-clear test on addr=9 leaves hazard_o=1.
- Reset mid-operation: assert rst_ni=0 while bit 9 is pending and a grant is in flight -> rf_w_ena_o=0 immediately. After release, hazard_o=0 for rs1=9.
- With REGFILE_WB_ARB_SB_CHECK_EN: MDU transfer to addr=3 with no prior issue -> sb_err_o=1 next cycle and held until reset. Without the macro, sb_err_o stays 0.
